// File: rtl/bp_slot_alloc_pkg.sv
// bp_slot_alloc_pkg
// Shared width helpers and status bundle for the slot allocation arbiter.
//   lg_els()  : pointer width for a pool of els slots
//   lg_cnt()  : occupancy counter width (must hold els itself)
//   lg_reqs() : requester index width (at least 1 bit)
//   slot_alloc_status_s : count/full/empty bundle for consumers that
//                         prefer a single status word
package bp_slot_alloc_pkg;

    function automatic int lg_els(input int els);
        return (els > 1) ? $clog2(els) : 1;
    endfunction

    function automatic int lg_cnt(input int els);
        return $clog2(els + 1);
    endfunction

    function automatic int lg_reqs(input int reqs);
        return (reqs > 1) ? $clog2(reqs) : 1;
    endfunction

    // Count field is sized for the largest pool we expect to build; consumers
    // zero-extend the arbiter's count_o into it.
    typedef struct packed {
        logic [31:0] count;
        logic        full;
        logic        empty;
    } slot_alloc_status_s;

endpackage

// File: rtl/bp_rr_arb.sv
// bp_rr_arb
// Rotating-priority arbiter: scans reqs starting at index prio, ascending
// modulo reqs_p, and grants the first set request when en is high.
//   reqs      : request vector
//   en        : grant enable (low forces grant_oh = 0)
//   prio      : index that gets first look this cycle (0..reqs_p-1)
//   grant_oh  : one-hot grant, or zero
//   grant_idx : encoded index of the granted requester (0 when none)
module bp_rr_arb
    import bp_slot_alloc_pkg::*;
#(
    parameter  int reqs_p     = 4,
    localparam int lg_reqs_lp = lg_reqs(reqs_p)
) (
    input  logic [reqs_p-1:0]     reqs,
    input  logic                  en,
    input  logic [lg_reqs_lp-1:0] prio,
    output logic [reqs_p-1:0]     grant_oh,
    output logic [lg_reqs_lp-1:0] grant_idx
);

    localparam logic [lg_reqs_lp:0] REQS_EXT = (lg_reqs_lp + 1)'(reqs_p);

    // cand_idx[k] is the requester examined k-th in this cycle's scan order.
    logic [lg_reqs_lp:0]   cand_sum  [reqs_p];
    logic [lg_reqs_lp:0]   cand_wrap [reqs_p];
    logic [lg_reqs_lp-1:0] cand_idx  [reqs_p];
    logic [reqs_p-1:0]     cand_v;
    logic [reqs_p-1:0]     unused_wrap_msb;

    generate
        for (genvar gi = 0; gi < reqs_p; gi++) begin : g_cand
            // prio + gi never exceeds 2*reqs_p-2, so one subtraction wraps it.
            assign cand_sum[gi]        = {1'b0, prio} + (lg_reqs_lp + 1)'(gi);
            assign cand_wrap[gi]       = (cand_sum[gi] >= REQS_EXT) ? (cand_sum[gi] - REQS_EXT)
                                                                    : cand_sum[gi];
            assign cand_idx[gi]        = cand_wrap[gi][lg_reqs_lp-1:0];
            assign unused_wrap_msb[gi] = cand_wrap[gi][lg_reqs_lp];
            assign cand_v[gi]          = reqs[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        logic found;
        found     = 1'b0;
        grant_oh  = '0;
        grant_idx = '0;
        for (int k = 0; k < reqs_p; k++) begin
            if (en && !found && cand_v[k]) begin
                found               = 1'b1;
                grant_idx           = cand_idx[k];
                grant_oh[cand_idx[k]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_slot_alloc_arbiter.sv
// bp_slot_alloc_arbiter
// Round-robin allocation controller for a circular slot pool. Each cycle at
// most one requester is granted the slot under the write pointer; dequeues
// release the oldest slot at the read pointer.
//   clk      : clock
//   reset_i  : asynchronous active-high reset
//   v_i      : per-requester allocation request
//   grant_o  : one-hot grant (combinational, zero-cycle latency)
//   slot_o   : slot index handed to the granted requester (write pointer)
//   deq_v_i  : release the slot at the read pointer (ignored when empty)
//   rptr_o   : oldest allocated slot
//   count_o  : number of allocated slots
//   full_o   : count_o == els_p
//   empty_o  : count_o == 0
module bp_slot_alloc_arbiter
    import bp_slot_alloc_pkg::*;
#(
    parameter  int els_p      = 64,
    parameter  int reqs_p     = 4,
    localparam int lg_els_lp  = lg_els(els_p),
    localparam int lg_cnt_lp  = lg_cnt(els_p),
    localparam int lg_reqs_lp = lg_reqs(reqs_p)
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic [reqs_p-1:0]    v_i,
    output logic [reqs_p-1:0]    grant_o,
    output logic [lg_els_lp-1:0] slot_o,
    input  logic                 deq_v_i,
    output logic [lg_els_lp-1:0] rptr_o,
    output logic [lg_cnt_lp-1:0] count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam logic [lg_els_lp:0]  ELS_LAST  = (lg_els_lp + 1)'(els_p - 1);
    localparam logic [lg_cnt_lp-1:0] CNT_FULL = lg_cnt_lp'(els_p);
    localparam logic [lg_reqs_lp-1:0] REQ_LAST = lg_reqs_lp'(reqs_p - 1);

    logic [lg_els_lp-1:0]  wptr_reg,  wptr_next;
    logic [lg_els_lp-1:0]  rptr_reg,  rptr_next;
    logic [lg_cnt_lp-1:0]  count_reg, count_next;
    logic [lg_reqs_lp-1:0] prio_reg,  prio_next;
    logic [lg_reqs_lp-1:0] grant_idx;
    logic                  grant_any;
    logic                  deq_eff;

    // Pointer increment done one bit wider and wrapped on an explicit compare,
    // so non-power-of-two pools wrap at els_p-1 rather than at 2**lg_els_lp.
    function automatic logic [lg_els_lp-1:0] ptr_inc(input logic [lg_els_lp-1:0] p);
        logic [lg_els_lp:0] ext;
        ext = {1'b0, p};
        if (ext == ELS_LAST) begin
            return '0;
        end
        ext = ext + (lg_els_lp + 1)'(1);
        return ext[lg_els_lp-1:0];
    endfunction

    assign full_o  = (count_reg == CNT_FULL);
    assign empty_o = (count_reg == '0);
    assign count_o = count_reg;
    assign rptr_o  = rptr_reg;
    assign slot_o  = wptr_reg;

    // A full pool blocks grants even if a dequeue lands this cycle: the freed
    // slot only becomes visible through count_reg next cycle.
    bp_rr_arb #(
        .reqs_p (reqs_p)
    ) u_arb (
        .reqs      (v_i),
        .en        (~full_o),
        .prio      (prio_reg),
        .grant_oh  (grant_o),
        .grant_idx (grant_idx)
    );

    assign grant_any = |grant_o;
    assign deq_eff   = deq_v_i & ~empty_o;

    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        prio_next  = prio_reg;
        count_next = count_reg;

        if (grant_any) begin
            wptr_next = ptr_inc(wptr_reg);
            prio_next = (grant_idx == REQ_LAST) ? '0 : grant_idx + lg_reqs_lp'(1);
        end

        if (deq_eff) begin
            rptr_next = ptr_inc(rptr_reg);
        end

        case ({grant_any, deq_eff})
            2'b10:   count_next = count_reg + lg_cnt_lp'(1);
            2'b01:   count_next = count_reg - lg_cnt_lp'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            prio_reg  <= '0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            count_reg <= count_next;
            prio_reg  <= prio_next;
        end
    end

endmodule
